// File: rtl/bank_htu_gen.sv
// Hit/tag unit for one cache bank: set-associative tag lookup, round-robin victim allocation,
// writeback/refill sequencing to sub-memory and per-set locking until the ISU reports done.
// Optional hit/miss statistics counters are enabled by defining BANK_HTU_STAT_EN.
module bank_htu_gen #(
  parameter int SET_NUM = 8,
  parameter int WAY_NUM = 4,
  parameter int OFF_NUM = 2,
  parameter int ADDR_W  = 32,
  parameter int WBID_W  = 8,
  parameter int CH_W    = 2,
  localparam int SETW   = $clog2(SET_NUM),
  localparam int WAYW   = $clog2(WAY_NUM),
  localparam int OW     = $clog2(OFF_NUM),
  localparam int SW     = SETW + WAYW,
  localparam int AW     = ADDR_W - 4,
  localparam int TAGW   = AW - OW - SETW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              xbar_bank_htu_valid_i,
  output logic              xbar_bank_htu_ready_o,
  input  logic [CH_W-1:0]   xbar_bank_htu_ch_id_i,
  input  logic [1:0]        xbar_bank_htu_opcode_i,
  input  logic [AW-1:0]     xbar_bank_htu_addr_i,
  input  logic [WBID_W-1:0] xbar_bank_htu_wbuffer_id_i,
  output logic              htu_isu_valid_o,
  input  logic              htu_isu_ready_i,
  output logic [CH_W-1:0]   htu_isu_ch_id_o,
  output logic [1:0]        htu_isu_opcode_o,
  output logic [WBID_W-1:0] htu_isu_wbuffer_id_o,
  output logic              htu_isu_hit_o,
  output logic [SW+OW-1:0]  htu_isu_set_way_offset_o,
  output logic [OFF_NUM-1:0] htu_isu_dirty_o,
  input  logic              isu_htu_done_valid_i,
  input  logic [SW-1:0]     isu_htu_done_set_way_i,
  output logic              htu_submem_valid_o,
  input  logic              htu_submem_ready_i,
  output logic [1:0]        htu_submem_opcode_o,
  output logic [SW-1:0]     htu_submem_set_way_o,
  output logic [AW-1:0]     htu_submem_addr_o
`ifdef BANK_HTU_STAT_EN
  ,
  output logic [31:0]       stat_hit_cnt_o,
  output logic [31:0]       stat_miss_cnt_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_RF, S_ISSUE} state_t;

  state_t              r_state;
  logic                r_ready;
  logic [CH_W-1:0]     r_ch;
  logic [1:0]          r_op;
  logic [WBID_W-1:0]   r_wbid;
  logic [TAGW-1:0]     r_reqTag;
  logic [SETW-1:0]     r_reqSet;
  logic [OW-1:0]       r_reqOff;
  logic                r_isuValid;
  logic                r_isuHit;
  logic [WAYW-1:0]     r_isuWay;
  logic [OFF_NUM-1:0]  r_isuDirty;
  logic                r_smValid;
  logic [1:0]          r_smOp;
  logic [AW-1:0]       r_smAddr;
  logic [WAYW-1:0]     r_vicWay;
  logic                r_vicNoInv;

  logic [TAGW-1:0]     r_tagArr  [SET_NUM][WAY_NUM];
  logic [OFF_NUM-1:0]  r_dirty   [SET_NUM][WAY_NUM];
  logic [WAY_NUM-1:0]  r_valid   [SET_NUM];
  logic [WAYW-1:0]     r_rr      [SET_NUM];
  logic [WAYW-1:0]     r_lockWay [SET_NUM];
  logic [SET_NUM-1:0]  r_lock;

  logic                w_hit;
  logic [WAYW-1:0]     w_hitWay;
  logic                w_anyInv;
  logic [WAYW-1:0]     w_invWay;
  logic [WAYW-1:0]     w_vicWay;
  logic                w_vicDirty;
  logic                w_isRw;
  logic                w_isuFire;
  logic                w_smFire;
  logic [SETW-1:0]     w_doneSet;
  logic [WAYW-1:0]     w_doneWay;

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    w_anyInv = 1'b0;
    w_invWay = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!r_valid[r_reqSet][w]) begin
        w_anyInv = 1'b1;
        w_invWay = WAYW'(w);
      end
      if (r_valid[r_reqSet][w] && (r_tagArr[r_reqSet][w] == r_reqTag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAYW'(w);
      end
    end
  end

  assign w_vicWay   = w_anyInv ? w_invWay : r_rr[r_reqSet];
  assign w_vicDirty = |r_dirty[r_reqSet][w_vicWay];
  assign w_isRw     = ~r_op[1];
  assign w_isuFire  = r_isuValid & htu_isu_ready_i;
  assign w_smFire   = r_smValid & htu_submem_ready_i;
  assign w_doneSet  = isu_htu_done_set_way_i[SW-1:WAYW];
  assign w_doneWay  = isu_htu_done_set_way_i[WAYW-1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_ch       <= '0;
      r_op       <= '0;
      r_wbid     <= '0;
      r_reqTag   <= '0;
      r_reqSet   <= '0;
      r_reqOff   <= '0;
      r_isuValid <= 1'b0;
      r_isuHit   <= 1'b0;
      r_isuWay   <= '0;
      r_isuDirty <= '0;
      r_smValid  <= 1'b0;
      r_smOp     <= '0;
      r_smAddr   <= '0;
      r_vicWay   <= '0;
      r_vicNoInv <= 1'b0;
      r_lock     <= '0;
      for (int s = 0; s < SET_NUM; s++) begin
        r_valid[s]   <= '0;
        r_rr[s]      <= '0;
        r_lockWay[s] <= '0;
        for (int w = 0; w < WAY_NUM; w++) begin
          r_tagArr[s][w] <= '0;
          r_dirty[s][w]  <= '0;
        end
      end
    end else begin
      // Done release comes first so a lock taken at the ISSUE handshake below wins.
      if (isu_htu_done_valid_i && r_lock[w_doneSet] && (r_lockWay[w_doneSet] == w_doneWay))
        r_lock[w_doneSet] <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (xbar_bank_htu_valid_i && r_ready) begin
            r_ready  <= 1'b0;
            r_ch     <= xbar_bank_htu_ch_id_i;
            r_op     <= xbar_bank_htu_opcode_i;
            r_wbid   <= xbar_bank_htu_wbuffer_id_i;
            r_reqOff <= xbar_bank_htu_addr_i[OW-1:0];
            r_reqSet <= xbar_bank_htu_addr_i[OW+SETW-1:OW];
            r_reqTag <= xbar_bank_htu_addr_i[AW-1:OW+SETW];
            r_state  <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (!r_lock[r_reqSet]) begin
            if (w_hit || !w_isRw) begin
              r_isuValid <= 1'b1;
              r_isuHit   <= w_hit;
              r_isuWay   <= w_hitWay;
              r_isuDirty <= w_hit ? r_dirty[r_reqSet][w_hitWay] : '0;
              r_state    <= S_ISSUE;
            end else begin
              r_vicWay   <= w_vicWay;
              r_vicNoInv <= ~w_anyInv;
              r_smValid  <= 1'b1;
              if (w_vicDirty) begin
                r_smOp   <= 2'b01;
                r_smAddr <= {r_tagArr[r_reqSet][w_vicWay], r_reqSet, OW'(0)};
                r_state  <= S_WB;
              end else begin
                r_smOp   <= 2'b00;
                r_smAddr <= {r_reqTag, r_reqSet, OW'(0)};
                r_state  <= S_RF;
              end
            end
          end
        end

        S_WB: begin
          if (w_smFire) begin
            r_smOp   <= 2'b00;
            r_smAddr <= {r_reqTag, r_reqSet, OW'(0)};
            r_state  <= S_RF;
          end
        end

        S_RF: begin
          if (w_smFire) begin
            r_tagArr[r_reqSet][r_vicWay] <= r_reqTag;
            r_valid[r_reqSet][r_vicWay]  <= 1'b1;
            r_dirty[r_reqSet][r_vicWay]  <= '0;
            if (r_vicNoInv)
              r_rr[r_reqSet] <= r_rr[r_reqSet] + WAYW'(1);
            r_smValid  <= 1'b0;
            r_isuValid <= 1'b1;
            r_isuHit   <= 1'b0;
            r_isuWay   <= r_vicWay;
            r_isuDirty <= '0;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_isuFire) begin
            r_isuValid <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= S_IDLE;
            case (r_op)
              2'b01: r_dirty[r_reqSet][r_isuWay][r_reqOff] <= 1'b1;
              2'b10: if (r_isuHit) r_dirty[r_reqSet][r_isuWay] <= '0;
              2'b11: if (r_isuHit) begin
                r_valid[r_reqSet][r_isuWay] <= 1'b0;
                r_dirty[r_reqSet][r_isuWay] <= '0;
              end
              default: ;
            endcase
            if (w_isRw || r_isuHit) begin
              r_lock[r_reqSet]    <= 1'b1;
              r_lockWay[r_reqSet] <= r_isuWay;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign xbar_bank_htu_ready_o    = r_ready;
  assign htu_isu_valid_o          = r_isuValid;
  assign htu_isu_ch_id_o          = r_ch;
  assign htu_isu_opcode_o         = r_op;
  assign htu_isu_wbuffer_id_o     = r_wbid;
  assign htu_isu_hit_o            = r_isuHit;
  assign htu_isu_set_way_offset_o = {r_reqSet, r_isuWay, r_reqOff};
  assign htu_isu_dirty_o          = r_isuDirty;
  assign htu_submem_valid_o       = r_smValid;
  assign htu_submem_opcode_o      = r_smOp;
  assign htu_submem_set_way_o     = {r_reqSet, r_vicWay};
  assign htu_submem_addr_o        = r_smAddr;

`ifdef BANK_HTU_STAT_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;

  // Only reads and writes are counted; both counters saturate.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (w_isuFire && w_isRw) begin
      if (r_isuHit) begin
        if (r_hitCnt != 32'hFFFF_FFFF) r_hitCnt <= r_hitCnt + 32'd1;
      end else begin
        if (r_missCnt != 32'hFFFF_FFFF) r_missCnt <= r_missCnt + 32'd1;
      end
    end
  end

  assign stat_hit_cnt_o  = r_hitCnt;
  assign stat_miss_cnt_o = r_missCnt;
`endif

endmodule

// File: tb/tb_bank_htu_gen.sv
// Directed, table-driven bench for bank_htu_gen (default parameters, statistics disabled).
module tb_bank_htu_gen;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        readyO;
  logic [1:0]  chI;
  logic [1:0]  opI;
  logic [27:0] addrI;
  logic [7:0]  wbidI;
  logic        isuValidO;
  logic        isuReady;
  logic [1:0]  isuCh;
  logic [1:0]  isuOp;
  logic [7:0]  isuWbid;
  logic        isuHit;
  logic [5:0]  isuSwo;
  logic [1:0]  isuDirty;
  logic        doneValid;
  logic [4:0]  doneSw;
  logic        smValidO;
  logic        smReady;
  logic [1:0]  smOpO;
  logic [4:0]  smSwO;
  logic [27:0] smAddrO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [27:0] addr;
    bit          expHit;
    logic [1:0]  expWay;
    bit          chkWay;
    logic [1:0]  expDirty;
    bit          expWb;
    logic [27:0] expWbAddr;
    bit          expRf;
    bit          sendDone;
  } vec_t;

  vec_t vecs[17];

  bank_htu_gen dut (
    .clk_i                      (clk),
    .rst_i                      (rstN),
    .xbar_bank_htu_valid_i      (reqValid),
    .xbar_bank_htu_ready_o      (readyO),
    .xbar_bank_htu_ch_id_i      (chI),
    .xbar_bank_htu_opcode_i     (opI),
    .xbar_bank_htu_addr_i       (addrI),
    .xbar_bank_htu_wbuffer_id_i (wbidI),
    .htu_isu_valid_o            (isuValidO),
    .htu_isu_ready_i            (isuReady),
    .htu_isu_ch_id_o            (isuCh),
    .htu_isu_opcode_o           (isuOp),
    .htu_isu_wbuffer_id_o       (isuWbid),
    .htu_isu_hit_o              (isuHit),
    .htu_isu_set_way_offset_o   (isuSwo),
    .htu_isu_dirty_o            (isuDirty),
    .isu_htu_done_valid_i       (doneValid),
    .isu_htu_done_set_way_i     (doneSw),
    .htu_submem_valid_o         (smValidO),
    .htu_submem_ready_i         (smReady),
    .htu_submem_opcode_o        (smOpO),
    .htu_submem_set_way_o       (smSwO),
    .htu_submem_addr_o          (smAddrO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  function automatic vec_t mk(input int op, input int addr, input int hit, input int way,
                              input int chk, input int d, input int wb, input int wbA,
                              input int rf, input int done);
    vec_t v;
    v.op = 2'(op); v.addr = 28'(addr); v.expHit = hit[0]; v.expWay = 2'(way);
    v.chkWay = chk[0]; v.expDirty = 2'(d); v.expWb = wb[0]; v.expWbAddr = 28'(wbA);
    v.expRf = rf[0]; v.sendDone = done[0];
    return v;
  endfunction

  function automatic logic [63:0] allOut();
    return 64'({readyO, isuValidO, isuCh, isuOp, isuWbid, isuHit, isuSwo, isuDirty,
                smValidO, smOpO, smSwO, smAddrO});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one request for a single accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [27:0] addr, input int idx);
    int w = 0;
    while (readyO !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput($sformatf("req%0d ready", idx), 64'(readyO), 64'd1);
    reqValid = 1'b1;
    opI      = op;
    addrI    = addr;
    chI      = 2'(idx);
    wbidI    = 8'(idx + 8'h40);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic runTxn(input vec_t v, input int idx);
    int cyc, smCnt, k;
    bit got, both;
    logic [1:0]  smOp[2];
    logic [27:0] smAddr[2];
    logic [4:0]  smSw[2];
    logic [27:0] lineA;
    logic [2:0]  setIdx;
    logic [5:0]  expSwo;
    logic [5:0]  swoMask;
    lineA   = {v.addr[27:1], 1'b0};
    setIdx  = v.addr[3:1];
    expSwo  = {setIdx, v.expWay, v.addr[0]};
    swoMask = v.chkWay ? 6'h3F : 6'h39;
    smCnt = 0; both = 1'b0; got = 1'b0; cyc = 1;
    for (int i = 0; i < 2; i++) begin
      smOp[i] = '0; smAddr[i] = '0; smSw[i] = '0;
    end
    applyStimulus(v.op, v.addr, idx);
    while (!got && cyc <= 40) begin
      if (isuValidO && smValidO) both = 1'b1;
      if (isuValidO) got = 1'b1;
      else begin
        if (smValidO) begin
          if (smCnt < 2) begin
            smOp[smCnt] = smOpO; smAddr[smCnt] = smAddrO; smSw[smCnt] = smSwO;
          end
          smCnt++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput($sformatf("v%0d issue", idx), 64'(got), 64'd1);
    if (got) begin
      checkOutput($sformatf("v%0d hit", idx), 64'(isuHit), 64'(v.expHit));
      checkOutput($sformatf("v%0d setWayOff", idx), 64'(isuSwo & swoMask), 64'(expSwo & swoMask));
      checkOutput($sformatf("v%0d dirty", idx), 64'(isuDirty), 64'(v.expDirty));
      checkOutput($sformatf("v%0d echo", idx), 64'({isuCh, isuOp, isuWbid}),
                  64'({2'(idx), v.op, 8'(idx + 8'h40)}));
      checkOutput($sformatf("v%0d latency", idx), 64'(cyc), 64'(2 + int'(v.expWb) + int'(v.expRf)));
      checkOutput($sformatf("v%0d submemCount", idx), 64'(smCnt), 64'(int'(v.expWb) + int'(v.expRf)));
      checkOutput($sformatf("v%0d exclusive", idx), 64'(both), 64'd0);
      if (v.expWb)
        checkOutput($sformatf("v%0d writeback", idx), 64'({smOp[0], smSw[0], smAddr[0]}),
                    64'({2'b01, setIdx, v.expWay, v.expWbAddr}));
      if (v.expRf) begin
        k = v.expWb ? 1 : 0;
        checkOutput($sformatf("v%0d refill", idx), 64'({smOp[k], smSw[k], smAddr[k]}),
                    64'({2'b00, setIdx, v.expWay, lineA}));
      end
      isuReady = 1'b1;
      @(negedge clk);
      isuReady = 1'b0;
      checkOutput($sformatf("v%0d isuDrop", idx), 64'(isuValidO), 64'd0);
      if (v.sendDone) begin
        doneValid = 1'b1;
        doneSw    = {setIdx, v.expWay};
        @(negedge clk);
        doneValid = 1'b0;
      end
    end
  endtask

  initial begin
    rstN = 1'b0; reqValid = 1'b0; chI = '0; opI = '0; addrI = '0; wbidI = '0;
    isuReady = 1'b0; doneValid = 1'b0; doneSw = '0; smReady = 1'b1;
    #12;
    checkOutput("resetOutputs", allOut(), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    //            op  addr    hit way chk dirty wb wbAddr rf done
    vecs[0]  = mk(0, 'h010, 0, 0, 1, 0, 0, 0,     1, 1);
    vecs[1]  = mk(0, 'h010, 1, 0, 1, 0, 0, 0,     0, 1);
    vecs[2]  = mk(1, 'h011, 1, 0, 1, 0, 0, 0,     0, 1);
    vecs[3]  = mk(0, 'h010, 1, 0, 1, 2, 0, 0,     0, 1);
    vecs[4]  = mk(0, 'h020, 0, 1, 1, 0, 0, 0,     1, 1);
    vecs[5]  = mk(0, 'h030, 0, 2, 1, 0, 0, 0,     1, 1);
    vecs[6]  = mk(0, 'h040, 0, 3, 1, 0, 0, 0,     1, 1);
    vecs[7]  = mk(0, 'h050, 0, 0, 1, 0, 1, 'h010, 1, 1);
    vecs[8]  = mk(0, 'h060, 0, 1, 1, 0, 0, 0,     1, 1);
    vecs[9]  = mk(3, 'h030, 1, 2, 1, 0, 0, 0,     0, 1);
    vecs[10] = mk(0, 'h030, 0, 2, 1, 0, 0, 0,     1, 1);
    vecs[11] = mk(3, 'h070, 0, 0, 0, 0, 0, 0,     0, 0);
    vecs[12] = mk(0, 'h030, 1, 2, 1, 0, 0, 0,     0, 1);
    vecs[13] = mk(1, 'h051, 1, 0, 1, 0, 0, 0,     0, 1);
    vecs[14] = mk(2, 'h050, 1, 0, 1, 2, 0, 0,     0, 1);
    vecs[15] = mk(0, 'h050, 1, 0, 1, 0, 0, 0,     0, 1);
    vecs[16] = mk(0, 'h013, 0, 0, 1, 0, 0, 0,     1, 1);

    for (int i = 0; i < 17; i++) runTxn(vecs[i], i);

    // Set 1 stays locked: no done for this hit.
    runTxn(mk(0, 'h013, 1, 0, 1, 0, 0, 0, 0, 0), 17);
    applyStimulus(2'b00, 28'h012, 18);
    repeat (3) @(negedge clk);
    checkOutput("lockStall", 64'(isuValidO), 64'd0);
    checkOutput("lockReady", 64'(readyO), 64'd0);
    doneValid = 1'b1; doneSw = 5'b010_00;
    @(negedge clk);
    doneValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("otherDone", 64'(isuValidO), 64'd0);
    doneValid = 1'b1; doneSw = 5'b001_00;
    @(negedge clk);
    doneValid = 1'b0;
    checkOutput("doneSameCycle", 64'(isuValidO), 64'd0);
    @(negedge clk);
    checkOutput("doneRelease", 64'(isuValidO), 64'd1);
    checkOutput("doneReleaseHit", 64'({isuHit, isuSwo}), 64'({1'b1, 6'b001_00_0}));
    isuReady = 1'b1;
    @(negedge clk);
    isuReady = 1'b0;
    doneValid = 1'b1; doneSw = 5'b001_00;
    @(negedge clk);
    doneValid = 1'b0;

    // Dirty way 2 of set 0 is the rr victim for tag 8; reset lands mid-writeback.
    runTxn(mk(1, 'h031, 1, 2, 1, 0, 0, 0, 0, 1), 19);
    smReady = 1'b0;
    applyStimulus(2'b00, 28'h080, 20);
    begin
      int w = 0;
      while (!smValidO && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    checkOutput("wbStart", 64'({smValidO, smOpO, smSwO, smAddrO}),
                64'({1'b1, 2'b01, 5'b000_10, 28'h030}));
    repeat (2) @(negedge clk);
    checkOutput("wbHold", 64'({smValidO, isuValidO}), 64'({1'b1, 1'b0}));
    #2 rstN = 1'b0;
    #1 checkOutput("midResetOutputs", allOut(), 64'd0);
    @(negedge clk);
    checkOutput("heldResetOutputs", allOut(), 64'd0);
    rstN = 1'b1;
    smReady = 1'b1;
    runTxn(mk(0, 'h050, 0, 0, 1, 0, 0, 0, 1, 1), 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_htu_gen.md
Name: bank_htu_gen

Overview:
Parametrised hit/tag unit for one cache bank, replacing the fixed 8-set single-entry tag lookup. Holds per-set/per-way tags with valid and per-offset dirty bits. Resolves hit/miss for read/write/flush/invalidate requests from the xbar and allocates victims round-robin on a miss. Sequences writeback/refill requests to sub-memory, then hands the request to the ISU, locking the set until the ISU reports done.

Parameters:
SET_NUM, 8, number of sets (power of 2, >=2)
WAY_NUM, 4, ways per set (power of 2, >=2)
OFF_NUM, 2, 16-byte sub-blocks per cacheline (power of 2, >=2)
ADDR_W, 32, byte address width
WBID_W, 8, write-buffer id width
CH_W, 2, channel id width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
xbar_bank_htu_valid_i  in  1  request valid
xbar_bank_htu_ready_o  out  1  request accepted when valid&ready
xbar_bank_htu_ch_id_i  in  CH_W  channel id
xbar_bank_htu_opcode_i  in  2  00 read, 01 write, 10 flush, 11 invalidate
xbar_bank_htu_addr_i  in  ADDR_W-4  addr[ADDR_W-1:4]
xbar_bank_htu_wbuffer_id_i  in  WBID_W  write-buffer id
htu_isu_valid_o  out  1  issue valid
htu_isu_ready_i  in  1  ISU ready
htu_isu_ch_id_o / opcode_o / wbuffer_id_o  out  CH_W/2/WBID_W  registered copies of the request
htu_isu_hit_o  out  1  1 = line was present at lookup
htu_isu_set_way_offset_o  out  SW+OW  {set, way, offset}; SW=log2(SET_NUM)+log2(WAY_NUM), OW=log2(OFF_NUM)
htu_isu_dirty_o  out  OFF_NUM  line dirty vector at lookup
isu_htu_done_valid_i  in  1  ISU completed the request
isu_htu_done_set_way_i  in  SW  {set, way} completed
htu_submem_valid_o  out  1  sub-memory request valid
htu_submem_ready_i  in  1  sub-memory ready
htu_submem_opcode_o  out  2  00 refill read, 01 writeback
htu_submem_set_way_o  out  SW  target {set, way}
htu_submem_addr_o  out  ADDR_W-4  line address (offset field zero)

Behaviour:
- Address split, offset-first above bit 4: offset = log2(OFF_NUM) bits, set = next log2(SET_NUM) bits, tag = remaining upper bits.
- Reset (rst_i=0, asynchronous): state IDLE; all valid, dirty, lock and round-robin pointers cleared; every output 0.
- FSM: IDLE, LOOKUP, WB, RF, ISSUE.
- IDLE: ready_o=1. On valid&ready, register the request and go to LOOKUP.
- LOOKUP: if the set's lock bit is set, stay. Otherwise compare the tag against all valid ways; at most one may hit.
- Read/write hit: go to ISSUE. A write sets dirty[offset] at the ISSUE handshake.
- Read/write miss, victim selection: lowest-index invalid way; if none, the set's rr pointer. If the victim has any dirty bit, go to WB, else RF.
- WB: submem_valid=1, opcode 01, address {victim tag, set, 0}. On handshake go to RF.
- RF: opcode 01→00 refill, address of the request line. On handshake:
  - write the tag and set valid;
  - clear all dirty bits;
  - if no invalid way existed, rr pointer += 1 mod WAY_NUM;
  - go to ISSUE with hit_o=0.
- Flush: go to ISSUE. The ISU moves the dirty data. On a hit, all dirty bits are cleared at the handshake.
- Invalidate: go to ISSUE. On a hit, valid and dirty are cleared at the handshake. On a miss, no state change.
- ISSUE: isu_valid_o=1; outputs are stable until handshake. On handshake, set the set's lock bit (except invalidate and flush misses) and go to IDLE.
- Lock: cleared when done_valid_i names a locked set. A done for an unlocked set is ignored. A done in the same cycle as lookup of that set is not visible until the next cycle.
- Latency, unlocked hit: accept in cycle 0, isu_valid_o in cycle 2.
- submem_valid_o and isu_valid_o are never high together. Valid is never withdrawn before its handshake.

Optional Feature:
BANK_HTU_STAT_EN:
- Defined: adds outputs stat_hit_cnt_o[31:0] and stat_miss_cnt_o[31:0].
  - Counted per read/write at the ISSUE handshake.
  - Saturate at 0xFFFFFFFF.
  - Reset to 0.
  - Flush and invalidate are not counted.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0000_0100 with submem ready=1 → one submem 00 for the line, then ISU hit_o=0, way=0. Repeat the read after done → no submem request, hit_o=1, isu_valid_o 2 cycles after accept.
- Write the same line at offset 1 → ISU hit=1, dirty_o=00. A subsequent read gives dirty_o=10.
- Fill all WAY_NUM ways of set 0 (one made dirty), then a new tag → writeback of the way-0 tag (rr=0) precedes the refill. The next miss evicts way 1.
- Issue a request, withhold done, send a second request to the same set → stalls in LOOKUP, ready_o=0. A done with a different set_way does not release it. A matching done → issue in the following cycle.
- Invalidate a hit line → later read misses. Invalidate a miss → hit_o=0, no lock, no submem request.
- Assert rst_i=0 mid-WB with submem ready=0 → all outputs 0 immediately. After release, the previously filled line misses.
